// File: rtl/spi_shift_ml.sv
// Multi-lane SPI master shift register: holds one character of up to MAX_CHAR bits,
// shifts it out over 1/2/4 lanes and captures the incoming lanes into the same register.
module spi_shift_ml #(
  parameter int MAX_CHAR = 128,
  parameter int LEN_BITS = 7,
  parameter int LANES    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAX_CHAR/32-1:0] latch,
  input  logic [3:0]            byte_sel,
  input  logic [31:0]           p_in,
  output logic [MAX_CHAR-1:0]   p_out,
  input  logic [LEN_BITS-1:0]   len,
  input  logic                  lsb,
  input  logic [1:0]            mode,
  input  logic                  go,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  input  logic                  rx_negedge,
  input  logic                  tx_negedge,
  input  logic [LANES-1:0]      s_in,
  output logic [LANES-1:0]      s_out,
  output logic [LANES-1:0]      lane_en,
  output logic                  tip,
  output logic                  last,
  output logic                  done
);

  localparam int NW = MAX_CHAR / 32;
  localparam int CW = LEN_BITS + 1;   // counters and lengths must hold MAX_CHAR itself
  localparam int IW = $clog2(MAX_CHAR);

  logic [MAX_CHAR-1:0] data, data_nxt;
  logic [CW-1:0]       tx_cnt, rx_cnt;
  logic [CW-1:0]       l_q, b_q, l_new, b_new, l_mask;
  logic [2:0]          w_q, w_new;
  logic [1:0]          wl_q, wl_new;
  logic [LANES-1:0]    lm_new, tx_grp, go_grp;
  logic [CW-1:0]       rx_off, tx_off;
  logic [IW-1:0]       wr_idx;
  logic                rx_stb, tx_stb, tx_adv, end_xfer;

  // Bit offset of group k within the character.
  function automatic logic [CW-1:0] grp_off(input logic [CW-1:0] k, input logic [CW-1:0] l,
                                            input logic [1:0] wl, input logic lsb_f);
    logic [CW-1:0] kw;
    kw = k << wl;
    return lsb_f ? kw : l - (CW'(1) << wl) - kw;
  endfunction

  function automatic logic [LANES-1:0] grp_get(input logic [MAX_CHAR-1:0] d,
                                               input logic [CW-1:0] off, input logic [2:0] w);
    logic [LANES-1:0] r;
    logic [IW-1:0]    idx;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(w)) begin
        idx  = IW'(int'(off) + j);
        r[j] = d[idx];
      end
    end
    return r;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wl_new = 2'd0;
    if (mode == 2'b01 && LANES >= 2)      wl_new = 2'd1;
    else if (mode == 2'b10 && LANES >= 4) wl_new = 2'd2;
    w_new  = 3'd1 << wl_new;
    l_mask = {1'b0, len} & ~(CW'(w_new) - CW'(1));
    l_new  = (len == '0) ? CW'(MAX_CHAR) : l_mask;
    if (l_new == '0) l_new = CW'(w_new);
    b_new  = l_new >> wl_new;
    lm_new = '0;
    for (int j = 0; j < LANES; j++) lm_new[j] = (j < int'(w_new));
  end

  assign rx_stb   = tip && (rx_negedge ? neg_edge : pos_edge) && (rx_cnt < b_q);
  assign tx_stb   = tip && (tx_negedge ? neg_edge : pos_edge);
  // tx may only run one group ahead of what has been (or is being) sampled.
  assign tx_adv   = tx_stb && ((rx_cnt + CW'(rx_stb)) > tx_cnt) && (tx_cnt < b_q - CW'(1));
  assign end_xfer = tip && (rx_cnt == b_q);
  assign last     = tip && (rx_cnt == b_q - CW'(1));

  assign rx_off = grp_off(rx_cnt, l_q, wl_q, lsb);
  assign tx_off = grp_off(tx_cnt + CW'(1), l_q, wl_q, lsb);
  assign tx_grp = grp_get(data, tx_off, w_q);
  assign go_grp = grp_get(data, grp_off(CW'(0), l_new, wl_new, lsb), w_new);

  always_comb begin
    data_nxt = data;
    wr_idx   = '0;
    if (!tip && !go) begin
      for (int i = 0; i < NW; i++)
        for (int b = 0; b < 4; b++)
          if (latch[i] && byte_sel[b]) data_nxt[32*i + 8*b +: 8] = p_in[8*b +: 8];
    end
    if (rx_stb) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < int'(w_q)) begin
          wr_idx           = IW'(int'(rx_off) + j);
          data_nxt[wr_idx] = s_in[j];
        end
      end
    end
  end

  // NOTE: the character register is reset along with the control state, since an abort must clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      s_out   <= '0;
      lane_en <= '0;
      tip     <= 1'b0;
      done    <= 1'b0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      l_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      wl_q    <= '0;
    end else begin
      data <= data_nxt;
      done <= 1'b0;
      if (!tip) begin
        if (go) begin
          tip     <= 1'b1;
          tx_cnt  <= '0;
          rx_cnt  <= '0;
          l_q     <= l_new;
          b_q     <= b_new;
          w_q     <= w_new;
          wl_q    <= wl_new;
          s_out   <= go_grp;
          lane_en <= lm_new;
        end else begin
          s_out <= '0;
        end
      end else if (end_xfer) begin
        tip     <= 1'b0;
        done    <= 1'b1;
        lane_en <= '0;
      end else begin
        if (rx_stb) rx_cnt <= rx_cnt + CW'(1);
        if (tx_adv) begin
          tx_cnt <= tx_cnt + CW'(1);
          s_out  <= tx_grp;
        end
      end
    end
  end

  assign p_out = data;

endmodule

// File: doc/spi_shift_ml.md
Name: spi_shift_ml

Overview:
- Parametrised, multi-lane successor of the SPI master shift register.
- Holds one character of up to MAX_CHAR bits, loaded from the 32-bit host bus one word at a time.
- Serialises the character over 1, 2 or 4 data lanes (single/dual/quad) while capturing the incoming lanes into the same register.
- Sits between the register file (latch/byte_sel/p_in/p_out) and the SCLK generator (pos_edge/neg_edge strobes).

Parameters:
MAX_CHAR, 128, shift-register width in bits; multiple of 32, range 32..256
LEN_BITS, 7, width of len; equals log2(MAX_CHAR)
LANES, 4, physical lanes; 1, 2 or 4
NW, MAX_CHAR/32, number of 32-bit host words (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
latch  in  NW  word write strobe, bit i selects data[32i+31:32i]
byte_sel  in  4  byte enables for latch
p_in  in  32  host write data
p_out  out  MAX_CHAR  shift-register contents
len  in  LEN_BITS  character length in bits; 0 means MAX_CHAR
lsb  in  1  1 = LSB group first
mode  in  2  00 single, 01 dual, 10 quad, 11 reserved (treated as single)
go  in  1  start request
pos_edge  in  1  one-clk strobe at SCLK rising edge
neg_edge  in  1  one-clk strobe at SCLK falling edge
rx_negedge  in  1  sample on falling edge
tx_negedge  in  1  drive on falling edge
s_in  in  LANES  serial inputs
s_out  out  LANES  serial outputs
lane_en  out  LANES  lanes active in current transfer
tip  out  1  transfer in progress
last  out  1  final beat pending
done  out  1  one-clk pulse at transfer end

Behaviour:
- Reset: data, s_out, lane_en, tip, last, done, tx_cnt and rx_cnt all 0.
- Lane width: W = 1/2/4 for mode 00/01/10. A mode whose W exceeds LANES is treated as single.
- Character length: L = MAX_CHAR if len==0, else len with its low log2(W) bits forced to 0. If this yields 0, L = W.
- Beat count: B = L/W. L, B and W are captured at go and stay fixed for the whole transfer.
- Group k (k = 0..B-1) covers bits data[g+W-1:g]:
  - g = k*W when lsb=1;
  - g = L-W-k*W when lsb=0.
- Lane j carries bit g+j of the group.
- Load: latch[i] && !tip && !go writes the byte_sel-enabled bytes of p_in to word i. Latch with tip or go high is ignored.
- Start: go && !tip sets tip=1 next clk, clears tx_cnt/rx_cnt/done, drives s_out with group 0, and sets lane_en low W bits = 1. go while tip is ignored.
- Strobes, qualified by tip:
  - rx_stb = (rx_negedge ? neg_edge : pos_edge) && rx_cnt < B;
  - tx_stb = (tx_negedge ? neg_edge : pos_edge).
- Receive: on rx_stb, group rx_cnt is written from s_in[W-1:0] and rx_cnt increments. Bits outside the group are untouched.
- Transmit: on tx_stb, if (rx_cnt + rx_stb) > tx_cnt and tx_cnt < B-1, then tx_cnt increments and s_out drives group tx_cnt+1 (read before any same-cycle rx write). Otherwise s_out holds.
  - This keeps tx always one group ahead of sampling, for both CPHA styles and for equal rx/tx edge settings.
- Unused lanes (j >= W) output 0.
- last = tip && rx_cnt == B-1.
- End: the clk after the rx_stb that makes rx_cnt == B:
  - tip=0, done=1 for exactly one clk, lane_en=0;
  - s_out returns to 0 on the following idle clk unless go is asserted.
- Idle: s_out = 0 when !tip && !go.
- Reset mid-transfer: all state returns to reset values immediately; data is cleared; no done pulse.
- rx_stb and tx_stb in the same clk are both applied.
- pos_edge and neg_edge in the same clk are illegal; the clock generator guarantees this never happens.

Test Plan:
1. Single, MSB first: mode=00, len=8, lsb=0, latch word0=0x000000A5, rx_negedge=0, tx_negedge=1, s_in fed 0x3C MSB-first -> s_out emits 1,0,1,0,0,1,0,1; after 8 rx samples done pulses once; p_out[7:0]=0x3C; tip high for exactly the transfer.
2. Quad, LSB first: mode=10, len=32, lsb=1, word0=0x12345678 -> s_out nibbles 8,7,6,5,4,3,2,1 over 8 beats; lane_en=4'hF during tip; s_in nibbles 0..7 give p_out[31:0]=0x76543210.
3. Full width, dual: len=0, mode=01, words 0..3 loaded -> B=64 beats, last high only on beat 63, all 128 bits captured.
4. Dual, odd len: len=9, mode=01 -> L=8, B=4; bit 8 unchanged after transfer.
5. Protection: latch word0=0xFFFFFFFF and a second go during tip -> data and counters unaffected; exactly one done.
6. Reset mid-transfer: rst at beat 3 of a 16-bit transfer -> tip, s_out, p_out = 0 at once; no done; a fresh go then works normally.
